// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, state encodings and select codes shared by the multi-cycle control unit.
package cpu_ctrl_pkg;
   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_XORI  = 6'b010011;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLTI  = 6'b100110;
   localparam logic [5:0] OP_SLT   = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;
   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;
   localparam logic [1:0] PC_NEXT = 2'd0;
   localparam logic [1:0] PC_BR   = 2'd1;
   localparam logic [1:0] PC_JR   = 2'd2;
   localparam logic [1:0] PC_J    = 2'd3;
   localparam logic [1:0] RD_R31  = 2'd0;
   localparam logic [1:0] RD_RT   = 2'd1;
   localparam logic [1:0] RD_RD   = 2'd2;
   function automatic logic [2:0] alu_op(input logic [5:0] op);
      return op == OP_SUB ? ALU_SUB :
             op inside {OP_AND, OP_ANDI} ? ALU_AND :
             op == OP_ORI ? ALU_OR :
             op == OP_XORI ? ALU_XOR :
             op == OP_SLL ? ALU_SLL :
             op inside {OP_SLT, OP_SLTI} ? ALU_SLT : ALU_ADD;
   endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: classifies an opcode into the instruction groups that steer sequencing and strobes.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] op,
   output logic       is_rtype,
   output logic       is_imm,
   output logic       zext,
   output logic       is_branch,
   output logic       is_ls,
   output logic       is_jump,
   output logic       is_halt
);
   assign is_rtype  = op inside {OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT};
   assign is_imm    = op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI};
   assign zext      = op inside {OP_ANDI, OP_ORI, OP_XORI};
   assign is_branch = op inside {OP_BEQ, OP_BNE, OP_BLTZ};
   assign is_ls     = op inside {OP_LW, OP_SW};
   assign is_jump   = op inside {OP_J, OP_JR, OP_JAL};
   assign is_halt   = op == OP_HALT;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB sequencer driving all datapath strobes and mux selects.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 3
) (
   input  logic           CLK,
   input  logic           Rst,
   input  logic [OPW-1:0] op,
   input  logic           zero,
   input  logic           sign,
   output logic           PCWre,
   output logic           IRWre,
   output logic           InsMemRW,
   output logic           ExtSel,
   output logic           ALUSrcA,
   output logic           ALUSrcB,
   output logic [2:0]     ALUOp,
   output logic           DBDataSrc,
   output logic           RegWre,
   output logic           RegWreDst,
   output logic [1:0]     RegDst,
   output logic           mRD,
   output logic           mWR,
   output logic [1:0]     PCSrc,
   output logic [STW-1:0] state
);
   state_t cur, nxt;
   logic halted, is_rtype, is_imm, zext, is_branch, is_ls, is_jump, is_halt, is_alu, taken;
   ctrl_decode u_dec (
      .op(op[5:0]), .is_rtype(is_rtype), .is_imm(is_imm), .zext(zext),
      .is_branch(is_branch), .is_ls(is_ls), .is_jump(is_jump), .is_halt(is_halt)
   );
   assign is_alu = is_rtype | is_imm;
   assign taken  = (op == OP_BEQ && zero) || (op == OP_BNE && !zero) || (op == OP_BLTZ && sign);
   assign state  = STW'(cur);
   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst) begin
         cur    <= S_IF;
         halted <= 1'b0;
      end else begin
         cur <= nxt;
         if (cur == S_ID && is_halt) halted <= 1'b1;
      end
   end
   always_comb begin
      nxt = S_IF;
      case (cur)
         S_IF:     nxt = halted ? S_IF : S_ID;
         S_ID:     nxt = is_branch ? S_EXE_BR : is_ls ? S_EXE_LS : is_alu ? S_EXE_AL : S_IF;
         S_EXE_AL: nxt = S_WB_AL;
         S_EXE_LS: nxt = S_MEM;
         S_MEM:    nxt = op == OP_LW ? S_WB_LD : S_IF;
         default:  nxt = S_IF;
      endcase
   end
   always_comb begin
      PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b1; ExtSel = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
      ALUOp = ALU_ADD; DBDataSrc = 1'b0; RegWre = 1'b0; RegWreDst = 1'b0; RegDst = RD_R31;
      mRD = 1'b0; mWR = 1'b0; PCSrc = PC_NEXT;
      case (cur)
         S_IF: IRWre = !halted;
         S_ID: begin
            // jumps retire here; undefined opcodes retire as a NOP advancing to PC+4
            PCWre  = is_jump || !(is_alu || is_branch || is_ls || is_halt);
            PCSrc  = op == OP_JR ? PC_JR : is_jump ? PC_J : PC_NEXT;
            RegWre = op == OP_JAL;
         end
         S_EXE_AL, S_WB_AL: begin
            ALUSrcA   = op == OP_SLL;
            ALUSrcB   = is_imm;
            ExtSel    = !zext;
            ALUOp     = alu_op(op[5:0]);
            RegWre    = cur == S_WB_AL;
            RegWreDst = cur == S_WB_AL;
            PCWre     = cur == S_WB_AL;
            RegDst    = cur != S_WB_AL ? RD_R31 : is_imm ? RD_RT : RD_RD;
         end
         S_EXE_BR: begin
            ALUOp  = ALU_SUB;
            ExtSel = 1'b1;
            PCWre  = 1'b1;
            PCSrc  = taken ? PC_BR : PC_NEXT;
         end
         S_EXE_LS, S_MEM: begin
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
            mRD     = cur == S_MEM && op == OP_LW;
            mWR     = cur == S_MEM && op == OP_SW;
            PCWre   = cur == S_MEM && op == OP_SW;
         end
         S_WB_LD: begin
            mRD       = 1'b1;
            DBDataSrc = 1'b1;
            RegWre    = 1'b1;
            RegWreDst = 1'b1;
            RegDst    = RD_RT;
            PCWre     = 1'b1;
         end
         default: ;
      endcase
      if (!Rst) begin
         PCWre = 1'b0; IRWre = 1'b0; RegWre = 1'b0; mWR = 1'b0; mRD = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction streams checked against a per-instruction cycle plan.
module tb_multicycle_ctrl;
   typedef struct packed {
      logic pcwre, irwre, insmem, extsel, srca, srcb;
      logic [2:0] aluop;
      logic dbsrc, regwre, wredst;
      logic [1:0] regdst;
      logic mrd, mwr;
      logic [1:0] pcsrc;
   } sb_t;
   logic CLK = 1'b0, Rst = 1'b0, zero = 1'b0, sign = 1'b0;
   logic [5:0] op = 6'b0;
   logic PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, RegWreDst, mRD, mWR;
   logic [2:0] ALUOp, state;
   logic [1:0] RegDst, PCSrc;
   sb_t got, eq_sb[$];
   logic [2:0] eq_st[$];
   int n_tests = 0, n_fail = 0;
   logic [5:0] ops[21] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                           6'b010011, 6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001,
                           6'b110100, 6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010,
                           6'b000011, 6'b101010, 6'b111110};
   multicycle_ctrl dut (
      .CLK(CLK), .Rst(Rst), .op(op), .zero(zero), .sign(sign), .PCWre(PCWre), .IRWre(IRWre),
      .InsMemRW(InsMemRW), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .DBDataSrc(DBDataSrc), .RegWre(RegWre), .RegWreDst(RegWreDst), .RegDst(RegDst), .mRD(mRD),
      .mWR(mWR), .PCSrc(PCSrc), .state(state)
   );
   assign got = {PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp, DBDataSrc, RegWre,
                 RegWreDst, RegDst, mRD, mWR, PCSrc};
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask
   function automatic sb_t base();
      sb_t b = '0;
      b.insmem = 1'b1;
      return b;
   endfunction
   // Expected per-cycle (state, strobes) for one instruction, derived from its class.
   function automatic void plan(input logic [5:0] o, input logic z, input logic s);
      sb_t f = base(), d = base(), e = base(), w = base();
      logic rt  = o inside {6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111};
      logic imm = o inside {6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110};
      logic br  = o inside {6'b110100, 6'b110101, 6'b110110};
      logic ls  = o inside {6'b110000, 6'b110001};
      logic jmp = o inside {6'b111000, 6'b111001, 6'b111010};
      logic [2:0] aop;
      case (o)
         6'b000001: aop = 3'b001;
         6'b010000, 6'b010001: aop = 3'b100;
         6'b010010: aop = 3'b011;
         6'b010011: aop = 3'b111;
         6'b011000: aop = 3'b010;
         6'b100110, 6'b100111: aop = 3'b110;
         default: aop = 3'b000;
      endcase
      eq_sb.delete(); eq_st.delete();
      f.irwre = 1'b1;
      eq_st.push_back(3'd0); eq_sb.push_back(f);
      if (jmp) begin
         d.pcwre = 1'b1;
         d.pcsrc = o == 6'b111001 ? 2'd2 : 2'd3;
         d.regwre = o == 6'b111010;
      end else if (!(rt || imm || br || ls || o == 6'b111111)) d.pcwre = 1'b1;
      eq_st.push_back(3'd1); eq_sb.push_back(d);
      if (rt || imm) begin
         e.srcb = imm;
         e.srca = o == 6'b011000;
         e.extsel = !(o inside {6'b010001, 6'b010010, 6'b010011});
         e.aluop = aop;
         eq_st.push_back(3'd6); eq_sb.push_back(e);
         e.regwre = 1'b1; e.wredst = 1'b1; e.pcwre = 1'b1;
         e.regdst = imm ? 2'd1 : 2'd2;
         eq_st.push_back(3'd7); eq_sb.push_back(e);
      end else if (br) begin
         e.aluop = 3'b001; e.extsel = 1'b1; e.pcwre = 1'b1;
         e.pcsrc = ((o == 6'b110100 && z) || (o == 6'b110101 && !z) || (o == 6'b110110 && s)) ? 2'd1 : 2'd0;
         eq_st.push_back(3'd5); eq_sb.push_back(e);
      end else if (ls) begin
         e.srcb = 1'b1; e.extsel = 1'b1;
         eq_st.push_back(3'd2); eq_sb.push_back(e);
         if (o == 6'b110001) e.mrd = 1'b1;
         else begin e.mwr = 1'b1; e.pcwre = 1'b1; end
         eq_st.push_back(3'd3); eq_sb.push_back(e);
         if (o == 6'b110001) begin
            w.mrd = 1'b1; w.dbsrc = 1'b1; w.regwre = 1'b1; w.wredst = 1'b1; w.regdst = 2'd1; w.pcwre = 1'b1;
            eq_st.push_back(3'd4); eq_sb.push_back(w);
         end
      end
   endfunction
   // Called at a falling edge while in sIF; returns at the falling edge of the next sIF.
   task automatic run_instr(input logic [5:0] o, input logic z, input logic s);
      int pcw = 0;
      op = o; zero = z; sign = s;
      plan(o, z, s);
      for (int k = 0; k < eq_st.size(); k++) begin
         #1;
         check($sformatf("state op=%b c%0d", o, k), 32'(state), 32'(eq_st[k]));
         check($sformatf("strobes op=%b c%0d", o, k), 32'(got), 32'(eq_sb[k]));
         pcw += int'(PCWre);
         @(negedge CLK);
      end
      check($sformatf("pcwre_count op=%b", o), 32'(pcw), o == 6'b111111 ? 32'd0 : 32'd1);
   endtask
   initial begin
      repeat (3) @(negedge CLK);
      #1 check("reset_state", 32'(state), 32'd0);
      check("reset_strobes", 32'(got), 32'(base()));
      #1 @(negedge CLK);
      Rst = 1'b1;
      run_instr(6'b000000, 1'b0, 1'b0);
      run_instr(6'b110001, 1'b0, 1'b0);
      run_instr(6'b110100, 1'b1, 1'b0);
      run_instr(6'b110100, 1'b0, 1'b0);
      run_instr(6'b110110, 1'b0, 1'b1);
      run_instr(6'b111010, 1'b0, 1'b0);
      run_instr(6'b110000, 1'b0, 1'b0);
      run_instr(6'b000011, 1'b0, 1'b0);
      for (int i = 0; i < 150; i++)
         run_instr(ops[$urandom_range(0, 20)], 1'($urandom), 1'($urandom));
      run_instr(6'b111111, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         op = ops[$urandom_range(0, 20)];
         #1 check("halted_state", 32'(state), 32'd0);
         check("halted_strobes", 32'(got), 32'(base()));
         @(negedge CLK);
      end
      #2 Rst = 1'b0;
      #1 check("halt_reset_state", 32'(state), 32'd0);
      @(negedge CLK);
      Rst = 1'b1;
      run_instr(6'b010010, 1'b0, 1'b0);
      op = 6'b110000;
      for (int k = 0; k < 3; k++) begin
         #1 check("sw_pre_state", 32'(state), 32'(k));
         @(negedge CLK);
      end
      #1 check("sw_mem_mwr", 32'(mWR), 32'd1);
      #2 Rst = 1'b0;
      #1 check("midreset_state", 32'(state), 32'd0);
      check("midreset_mwr", 32'(mWR), 32'd0);
      check("midreset_pcwre", 32'(PCWre), 32'd0);
      check("midreset_strobes", 32'(got), 32'(base()));
      @(negedge CLK);
      Rst = 1'b1;
      for (int i = 0; i < 20; i++)
         run_instr(ops[$urandom_range(0, 20)], 1'($urandom), 1'($urandom));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
